// File: rtl/fan_ctrl_pkg.sv
// Shared register map, mode bits, ramp state encoding and clamp helper for the fan bank.
// Pure declarations: no latency and no backpressure apply.
// Imported by multi_fan_control and fan_pwm_channel.
package fan_ctrl_pkg;

  localparam logic [2:0] REG_PERIOD  = 3'd0;
  localparam logic [2:0] REG_DUTY    = 3'd1;
  localparam logic [2:0] REG_MODE    = 3'd2;
  localparam logic [2:0] REG_SENS    = 3'd3;
  localparam logic [2:0] REG_CURRENT = 3'd4;
  localparam logic [2:0] REG_ACTIVE  = 3'd5;
  localparam logic [2:0] REG_TACH    = 3'd6;
  localparam logic [2:0] REG_RSVD    = 3'd7;

  localparam int MODE_AUTO = 0;
  localparam int MODE_RAMP = 1;

  typedef enum logic [1:0] {
    RAMP_HOLD = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_state_t;

  function automatic longint clamp_ll(input longint v, input longint lo, input longint hi);
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/multi_fan_control_if.sv
// Avalon-MM slave bundle for the fan controller register space.
// Latency set by the slave: reads stall one cycle via waitrequest, writes are zero-wait.
// Master drives address/strobes/writedata; slave returns readdata/waitrequest.
interface multi_fan_control_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [31:0]       writedata;
  logic              read;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/fan_pwm_channel.sv
// One fan: PWM counter, double-buffered period/duty, ramp FSM, auto duty, optional tach (FAN_TACH_EN).
// Latency: register writes land next edge; period/duty reach the output only at the PWM wrap.
// Backpressure: none, writes always accepted; register readback is combinational.
module fan_pwm_channel
  import fan_ctrl_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 50_000_000,
  parameter int DUTY_WIDTH     = 16,
  parameter int DEFAULT_PERIOD = 50_000,
  parameter int AUTO_SHIFT     = 8,
  parameter int RAMP_STEP      = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [2:0]  wr_reg,
  input  logic [31:0] wr_data,
  input  logic [2:0]  rd_reg,
  output logic [31:0] rd_data,
  input  logic [31:0] current_average,
  input  logic        tach,
  output logic        pwm
);

  localparam longint PERIOD_MAX = (longint'(1) << DUTY_WIDTH) - 1;

  typedef logic [DUTY_WIDTH-1:0] duty_t;

  duty_t       period_reg, period_act, duty_target, duty_active, counter;
  duty_t       target, duty_next, counter_next, period_next;
  logic [1:0]  mode;
  logic [31:0] sensitivity;
  logic [15:0] tach_count;
  logic        wrap;
  ramp_state_t ramp_q, ramp_d;

  longint wr_val, product, scaled, target_raw;

  assign wr_val  = longint'($signed(wr_data));
  assign product = longint'($signed(current_average)) * longint'($signed(sensitivity));
  assign scaled  = product >>> AUTO_SHIFT;

  // Target is always bounded by the period that will be live after the next wrap.
  assign target_raw = mode[MODE_AUTO] ? scaled : longint'(duty_target);
  assign target     = duty_t'(clamp_ll(target_raw, 0, longint'(period_reg)));

  assign wrap         = (counter >= period_act - duty_t'(1));
  assign counter_next = wrap ? '0 : counter + duty_t'(1);
  assign period_next  = wrap ? period_reg : period_act;

  always_comb begin
    ramp_d    = ramp_q;
    duty_next = duty_active;
    if (wrap) begin
      if (!mode[MODE_RAMP]) begin
        ramp_d    = RAMP_HOLD;
        duty_next = target;
      end else begin
        if (target > duty_active)      ramp_d = RAMP_UP;
        else if (target < duty_active) ramp_d = RAMP_DOWN;
        else                           ramp_d = RAMP_HOLD;
        case (ramp_d)
          RAMP_UP:   duty_next = (target - duty_active > duty_t'(RAMP_STEP))
                                 ? duty_active + duty_t'(RAMP_STEP) : target;
          RAMP_DOWN: duty_next = (duty_active - target > duty_t'(RAMP_STEP))
                                 ? duty_active - duty_t'(RAMP_STEP) : target;
          default:   duty_next = duty_active;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      period_reg  <= duty_t'(DEFAULT_PERIOD);
      period_act  <= duty_t'(DEFAULT_PERIOD);
      duty_target <= '0;
      duty_active <= '0;
      counter     <= '0;
      mode        <= '0;
      sensitivity <= 32'd1;
      ramp_q      <= RAMP_HOLD;
      pwm         <= 1'b0;
    end else begin
      counter     <= counter_next;
      period_act  <= period_next;
      duty_active <= duty_next;
      ramp_q      <= ramp_d;
      // Registered compare keeps pwm == (counter < duty_active) with no decode glitches.
      pwm         <= (counter_next < duty_next);
      if (wr_en) begin
        case (wr_reg)
          REG_PERIOD: period_reg  <= duty_t'(clamp_ll(wr_val, 2, PERIOD_MAX));
          REG_DUTY:   duty_target <= duty_t'(clamp_ll(wr_val, 0, longint'(period_reg)));
          REG_MODE:   mode        <= wr_data[1:0];
          REG_SENS:   sensitivity <= wr_data;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_reg)
      REG_PERIOD:  rd_data = 32'(period_reg);
      REG_DUTY:    rd_data = 32'(duty_target);
      REG_MODE:    rd_data = {30'd0, mode};
      REG_SENS:    rd_data = sensitivity;
      REG_CURRENT: rd_data = current_average;
      REG_ACTIVE:  rd_data = 32'(duty_active);
      REG_TACH:    rd_data = 32'(tach_count);
      REG_RSVD:    rd_data = '0;
      default:     rd_data = '0;
    endcase
  end

`ifdef FAN_TACH_EN
  localparam int WINDOW = CLOCK_SPEED_HZ / 2;

  logic [2:0]  tach_sync;
  logic [31:0] win_cnt;
  logic [15:0] edge_cnt, edge_inc;
  logic        tach_rise;

  assign tach_rise = tach_sync[1] & ~tach_sync[2];
  assign edge_inc  = (tach_rise && edge_cnt != 16'hFFFF) ? edge_cnt + 16'd1 : edge_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tach_sync  <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      tach_count <= '0;
    end else begin
      tach_sync <= {tach_sync[1:0], tach};
      if (win_cnt >= 32'(WINDOW - 1)) begin
        win_cnt    <= '0;
        tach_count <= edge_inc;
        edge_cnt   <= '0;
      end else begin
        win_cnt  <= win_cnt + 32'd1;
        edge_cnt <= edge_inc;
      end
    end
  end
`else
  logic unused_tach;
  assign unused_tach = tach;
  assign tach_count  = '0;
`endif

endmodule

// File: rtl/multi_fan_control.sv
// Multi-channel fan PWM controller: Avalon-MM decode, readdata mux, NUM_CHANNELS fan_pwm_channel (tach via FAN_TACH_EN).
// Latency: reads return data one cycle after acceptance; writes take effect on the next edge.
// Backpressure: waitrequest high only during the first cycle of each read; writes never stall.
module multi_fan_control
  import fan_ctrl_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 50_000_000,
  parameter int NUM_CHANNELS   = 4,
  parameter int DUTY_WIDTH     = 16,
  parameter int DEFAULT_PERIOD = 50_000,
  parameter int AUTO_SHIFT     = 8,
  parameter int RAMP_STEP      = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  multi_fan_control_if.slave           bus,
  input  logic [NUM_CHANNELS*32-1:0]   current_average,
  input  logic [NUM_CHANNELS-1:0]      tach,
  output logic [NUM_CHANNELS-1:0]      pwm
);

  localparam int ADDR_W = $clog2(NUM_CHANNELS) + 3;

  logic [ADDR_W-1:0] ch_sel;
  logic [2:0]        reg_sel;
  logic [31:0]       ch_rdata [NUM_CHANNELS];
  logic [31:0]       rd_mux;
  logic              rd_pend;

  assign ch_sel          = bus.address >> 3;
  assign reg_sel         = bus.address[2:0];
  assign bus.waitrequest = bus.read && !rd_pend;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    fan_pwm_channel #(
      .CLOCK_SPEED_HZ (CLOCK_SPEED_HZ),
      .DUTY_WIDTH     (DUTY_WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .AUTO_SHIFT     (AUTO_SHIFT),
      .RAMP_STEP      (RAMP_STEP)
    ) u_ch (
      .clk             (clk),
      .reset_n         (reset_n),
      .wr_en           (bus.write && (ch_sel == ADDR_W'(i))),
      .wr_reg          (reg_sel),
      .wr_data         (bus.writedata),
      .rd_reg          (reg_sel),
      .rd_data         (ch_rdata[i]),
      .current_average (current_average[32*i +: 32]),
      .tach            (tach[i]),
      .pwm             (pwm[i])
    );
  end

  // Channel indices past NUM_CHANNELS fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (ch_sel == ADDR_W'(i)) rd_mux = ch_rdata[i];
    end
  end

  // Data is sampled in the stall cycle, so a same-cycle write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pend      <= 1'b0;
      bus.readdata <= '0;
    end else if (bus.read && !rd_pend) begin
      rd_pend      <= 1'b1;
      bus.readdata <= rd_mux;
    end else begin
      rd_pend      <= 1'b0;
    end
  end

endmodule
